pwm_driver: RTL
===============

# pwm_driver

Multi-channel 8-bit PWM generator that turns the 8-bit brightness/position values produced by the sculpture's fade counters into pulse-width-modulated output pins. Each channel has a shadow duty register written over a simple write strobe and an active duty register updated only at a period boundary, so outputs never glitch mid-period. Sits between the value generators and the LED/servo driver pins.

## Interface
- CHANNELS, 4, number of independent PWM outputs (1..16)
- PRESCALE, 16, clk cycles per PWM phase step (1..65536); PWM period = 256*PRESCALE clk cycles
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write strobe for a shadow duty register, one write per asserted cycle
- wr_ch  input  $clog2(CHANNELS) (min 1)  channel index for the write
- wr_duty  input  8  duty value, high time in phase steps (0..255)
- pwm  output  CHANNELS  registered PWM outputs, bit i = channel i
- period_start  output  1  one-cycle pulse marking phase 0 of each period

## Operation
- Prescaler: counter 0..PRESCALE-1; tick asserted in the cycle the prescaler equals PRESCALE-1, then it wraps to 0. PRESCALE=1 → tick every cycle.
- Phase counter: 8-bit, increments on tick, wraps 255→0 (natural modulo-256, no saturation).
- Shadow registers: on wr_en with wr_ch < CHANNELS, shadow[wr_ch] <= wr_duty. wr_ch >= CHANNELS: write silently dropped, no state change. Writes always accepted, no back-pressure.
- Period update: on the tick where phase == 255 (phase wraps to 0), active[i] <= shadow[i] for all i simultaneously.
- Simultaneous write and period update in the same cycle: active takes the pre-write shadow value; new value takes effect the following period.
- Output compare: pwm[i] <= (phase < active[i]) each cycle. duty 0 → constantly low; duty 255 → high 255 of 256 steps (never 100%; accepted limitation).
- period_start <= 1 exactly in the cycle after the wrap tick (phase register reads 0 for first time in that period), else 0.
- Reset: prescaler, phase, all shadow and active registers to 0; pwm all 0; period_start 0. Reset mid-period abandons the period; first post-reset period begins with phase 0 and active 0 (outputs low until a write plus a full period boundary).

## Timing
- Write-to-effect latency: write lands in shadow next edge; visible in pwm from the first period boundary after that, +1 cycle output register lag.
- pwm lags phase by exactly 1 clk (registered compare on registered phase).
- After rst deasserts: first tick at cycle PRESCALE (counting the first non-reset edge as cycle 1); first wrap after 256 ticks.
- period_start pulse period = 256*PRESCALE cycles exactly; width 1 cycle regardless of PRESCALE (including PRESCALE=1).
- Channel outputs rise together at period start (all channels with active>0 go high in the cycle after phase becomes 0) — left-aligned PWM.

## Structure
- Shared package: PWM_WIDTH=8 constant, PHASE_MAX=255 constant; CHANNELS/PRESCALE stay module parameters.
- One natural sub-module: pwm_prescaler (parameter PRESCALE; outputs tick), reusable by other timing blocks in the sculpture.
- Per-channel shadow/active/compare in a generate loop inside pwm_driver.

## Test plan
- Reset: hold rst 3 cycles mid-run with outputs active → pwm=0, period_start=0 next edge, phase restarts at 0, no output until rewrite.
- PRESCALE=1, write ch0=64 then wait a boundary → pwm[0] high exactly 64 consecutive cycles per 256-cycle period, period_start every 256 cycles.
- Extremes, PRESCALE=1: duty 0 → pwm low all 256 cycles; duty 255 → high 255, low 1 per period; duty 128 → 128/128.
- Write ch1=200 mid-period while active=50 → remainder of current period shows 50-step compare; next period 200 high cycles.
- Write coinciding with wrap tick (ch2 shadow=10, write 99 same cycle) → next period high 10 cycles, following period 99.
- Out-of-range wr_ch (CHANNELS=3, wr_ch=3, duty=77) → no channel changes; PRESCALE=16 check period_start spacing = 4096 cycles.

Source files
------------

// File: rtl/pwm_driver_pkg.sv
// Shared constants and types for the PWM driver and related timing blocks.
// The phase counter and duty registers are all PWM_WIDTH bits wide.
package pwm_driver_pkg;

    localparam int PWM_WIDTH = 8;

    typedef logic [PWM_WIDTH-1:0] duty_t;

    localparam duty_t PHASE_MAX = 8'd255;

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running clock divider: tick is high for one cycle out of every PRESCALE cycles.
// The divider is also intended for reuse by other timing blocks in the sculpture.
module pwm_prescaler #(
    parameter int PRESCALE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With PRESCALE=1 the counter stays at 0 and tick is permanently high.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_driver.sv
// Multi-channel left-aligned 8-bit PWM generator. Each channel holds a shadow duty register
// that is copied into the active duty register at every period wrap, so outputs never glitch.
module pwm_driver
    import pwm_driver_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 16
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  wr_en,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]    wr_ch,
    input  logic [PWM_WIDTH-1:0]                                  wr_duty,
    output logic [CHANNELS-1:0]                                   pwm,
    output logic                                                  period_start
);

    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CHW:0] CH_LIMIT = CHANNELS[CHW:0];

    logic  tick;
    logic  wrap;
    logic  wr_valid;
    duty_t phase_q;
    duty_t phase_d;
    logic  period_start_q;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Indices beyond the channel count are dropped without touching any register.
    always_comb begin
        wrap     = tick && (phase_q == PHASE_MAX);
        phase_d  = tick ? phase_q + 8'd1 : phase_q;
        wr_valid = wr_en && ({1'b0, wr_ch} < CH_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q        <= '0;
            period_start_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            period_start_q <= wrap;
        end
    end

    assign period_start = period_start_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_channel
            localparam logic [CHW-1:0] CH_IDX = CHW'(gi);

            duty_t shadow_q;
            duty_t shadow_d;
            duty_t active_q;
            duty_t active_d;
            logic  pwm_q;
            logic  pwm_d;

            // A write landing on the wrap edge still lets active take the old shadow value.
            always_comb begin
                shadow_d = shadow_q;
                active_d = active_q;
                if (wr_valid && (wr_ch == CH_IDX)) begin
                    shadow_d = wr_duty;
                end
                if (wrap) begin
                    active_d = shadow_q;
                end
                pwm_d = (phase_q < active_q);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_q <= '0;
                    active_q <= '0;
                    pwm_q    <= 1'b0;
                end else begin
                    shadow_q <= shadow_d;
                    active_q <= active_d;
                    pwm_q    <= pwm_d;
                end
            end

            assign pwm[gi] = pwm_q;
        end
    endgenerate

endmodule
